// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI output timing path: pixel type,
// default 640x480 VGA timing, controller states and the colour-bar table.
`timescale 1ns/1ps
package hdmi_pkg;

  localparam int PKG_BPP = 24;
  typedef logic [PKG_BPP-1:0] pixel_t;

  localparam int VGA_H_RES  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_RES  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  // White, yellow, cyan, green, magenta, red, blue, black.
  localparam pixel_t COLOUR_BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/hdmi_timing_counter.sv
// Raster position counters and region decode (active, sync, last pixel of frame).
`timescale 1ns/1ps
module hdmi_timing_counter
  import hdmi_pkg::*;
#(
  parameter int H_RES_PIX = VGA_H_RES,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_RES_PIX = VGA_V_RES,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int HCW       = $clog2(H_RES_PIX + H_FP + H_SYNC + H_BP),
  parameter int VCW       = $clog2(V_RES_PIX + V_FP + V_SYNC + V_BP)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           run_i,
  output logic [HCW-1:0] h_cnt_o,
  output logic [VCW-1:0] v_cnt_o,
  output logic           active_o,
  output logic           hs_region_o,
  output logic           vs_region_o,
  output logic           frame_end_o
);

  localparam int H_TOTAL = H_RES_PIX + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES_PIX + V_FP + V_SYNC + V_BP;

  logic [HCW-1:0] h_q, h_d;
  logic [VCW-1:0] v_q, v_d;
  logic           h_last, v_last;

  assign h_last = (h_q == HCW'(H_TOTAL - 1));
  assign v_last = (v_q == VCW'(V_TOTAL - 1));

  // Counters sit at the origin whenever the raster is not running.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!run_i) begin
      h_d = '0;
      v_d = '0;
    end else if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o     = h_q;
  assign v_cnt_o     = v_q;
  assign active_o    = (h_q < HCW'(H_RES_PIX)) && (v_q < VCW'(V_RES_PIX));
  assign hs_region_o = (h_q >= HCW'(H_RES_PIX + H_FP)) &&
                       (h_q <  HCW'(H_RES_PIX + H_FP + H_SYNC));
  assign vs_region_o = (v_q >= VCW'(V_RES_PIX + V_FP)) &&
                       (v_q <  VCW'(V_RES_PIX + V_FP + V_SYNC));
  assign frame_end_o = h_last && v_last;

endmodule

// File: rtl/hdmi_out_timing_gen.sv
// HDMI transmit timing generator: frame-buffer read requests plus a two-stage
// output pipeline. Optional colour bars via HDMI_OUT_TEST_PATTERN_EN.
`timescale 1ns/1ps
module hdmi_out_timing_gen
  import hdmi_pkg::*;
#(
  parameter int H_RES_PIX      = VGA_H_RES,
  parameter int H_FP           = VGA_H_FP,
  parameter int H_SYNC         = VGA_H_SYNC,
  parameter int H_BP           = VGA_H_BP,
  parameter int V_RES_PIX      = VGA_V_RES,
  parameter int V_FP           = VGA_V_FP,
  parameter int V_SYNC         = VGA_V_SYNC,
  parameter int V_BP           = VGA_V_BP,
  parameter int BITS_PER_PIXEL = PKG_BPP,
  parameter int HS_POL         = 1,
  parameter int VS_POL         = 1,
  parameter int HPW            = $clog2(H_RES_PIX),
  parameter int VPW            = $clog2(V_RES_PIX)
) (
  input  logic                      vid_clk,
  input  logic                      reset_n,
  input  logic                      en,
`ifdef HDMI_OUT_TEST_PATTERN_EN
  input  logic                      tp_sel,
`endif
  output logic [HPW-1:0]            Hpos,
  output logic [VPW-1:0]            Vpos,
  output logic                      pix_req,
  output logic                      frame_start,
  input  logic [BITS_PER_PIXEL-1:0] pixel_in,
  output logic                      Hsync,
  output logic                      Vsync,
  output logic                      Active_pix,
  output logic [BITS_PER_PIXEL-1:0] pixel_out
);

  localparam int   HCW    = $clog2(H_RES_PIX + H_FP + H_SYNC + H_BP);
  localparam int   VCW    = $clog2(V_RES_PIX + V_FP + V_SYNC + V_BP);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  state_e         state_q, state_d;
  logic           running;
  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           active, hs_region, vs_region, frame_end;

  hdmi_timing_counter #(
    .H_RES_PIX(H_RES_PIX), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_RES_PIX(V_RES_PIX), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HCW(HCW), .VCW(VCW)
  ) u_counter (
    .clk_i      (vid_clk),
    .rst_ni     (reset_n),
    .run_i      (running),
    .h_cnt_o    (h_cnt),
    .v_cnt_o    (v_cnt),
    .active_o   (active),
    .hs_region_o(hs_region),
    .vs_region_o(vs_region),
    .frame_end_o(frame_end)
  );

  always_ff @(posedge vid_clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A dropped enable only stops the raster on the last pixel of a frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (en) state_d = RUN;
      RUN:      if (!en) state_d = frame_end ? IDLE : STOPPING;
      STOPPING: if (en) state_d = RUN;
                else if (frame_end) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb running = (state_q != IDLE);

  logic           req_d;
  logic           pix_req_q, fs_q, hs_p1_q, vs_p1_q;
  logic [HPW-1:0] hpos_q;
  logic [VPW-1:0] vpos_q;

  assign req_d = running && active;

  // Stage 1: read request to the frame buffer
  always_ff @(posedge vid_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_req_q <= 1'b0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      fs_q      <= 1'b0;
      hs_p1_q   <= 1'b0;
      vs_p1_q   <= 1'b0;
    end else begin
      pix_req_q <= req_d;
      hpos_q    <= req_d ? HPW'(h_cnt) : '0;
      vpos_q    <= req_d ? VPW'(v_cnt) : '0;
      fs_q      <= running && (h_cnt == '0) && (v_cnt == '0);
      hs_p1_q   <= running && hs_region;
      vs_p1_q   <= running && vs_region;
    end
  end

  logic [BITS_PER_PIXEL-1:0] pix_src, pix_d;

`ifdef HDMI_OUT_TEST_PATTERN_EN
  localparam int BAR_W = H_RES_PIX / 8;
  logic [2:0] bar_idx;
  assign bar_idx = 3'(hpos_q / HPW'(BAR_W));
`endif

  always_comb begin
    pix_src = pixel_in;
`ifdef HDMI_OUT_TEST_PATTERN_EN
    if (tp_sel) pix_src = BITS_PER_PIXEL'(COLOUR_BARS[bar_idx]);
`endif
    pix_d = pix_req_q ? pix_src : '0;
  end

  logic                      act_p2_q, hs_p2_q, vs_p2_q;
  logic [BITS_PER_PIXEL-1:0] pix_p2_q;

  // Stage 2: registered pixel and syncs to the encoder
  always_ff @(posedge vid_clk or negedge reset_n) begin
    if (!reset_n) begin
      act_p2_q <= 1'b0;
      pix_p2_q <= '0;
      hs_p2_q  <= ~HS_ACT;
      vs_p2_q  <= ~VS_ACT;
    end else begin
      act_p2_q <= pix_req_q;
      pix_p2_q <= pix_d;
      hs_p2_q  <= hs_p1_q ? HS_ACT : ~HS_ACT;
      vs_p2_q  <= vs_p1_q ? VS_ACT : ~VS_ACT;
    end
  end

  assign pix_req     = pix_req_q;
  assign Hpos        = hpos_q;
  assign Vpos        = vpos_q;
  assign frame_start = fs_q;
  assign Active_pix  = act_p2_q;
  assign pixel_out   = pix_p2_q;
  assign Hsync       = hs_p2_q;
  assign Vsync       = vs_p2_q;

endmodule

// File: tb/tb_hdmi_out_timing_gen.sv
// Bench for hdmi_out_timing_gen with a reduced 14x8 raster, random frame-buffer
// contents and enable patterns, checked against a raster-position reference model.
`timescale 1ns/1ps
module tb_hdmi_out_timing_gen;

  localparam int HR = 8, HF = 2, HS = 3, HB = 1;
  localparam int VR = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HR + HF + HS + HB;
  localparam int VT = VR + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        vid_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en      = 1'b0;
  logic [2:0]  Hpos;
  logic [1:0]  Vpos;
  logic        pix_req, frame_start, Hsync, Vsync, Active_pix;
  logic [23:0] pixel_in, pixel_out;
  logic [23:0] mem [VR][HR];

  int checks = 0;
  int errors = 0;

  always #5 vid_clk = ~vid_clk;

  // Frame buffer: data for the requested position, ready the next cycle.
  assign pixel_in = mem[Vpos][Hpos];

  hdmi_out_timing_gen #(
    .H_RES_PIX(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_RES_PIX(VR), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BITS_PER_PIXEL(24), .HS_POL(1), .VS_POL(1)
  ) dut (
    .vid_clk    (vid_clk),
    .reset_n    (reset_n),
    .en         (en),
`ifdef HDMI_OUT_TEST_PATTERN_EN
    .tp_sel     (1'b0),
`endif
    .Hpos       (Hpos),
    .Vpos       (Vpos),
    .pix_req    (pix_req),
    .frame_start(frame_start),
    .pixel_in   (pixel_in),
    .Hsync      (Hsync),
    .Vsync      (Vsync),
    .Active_pix (Active_pix),
    .pixel_out  (pixel_out)
  );

  // Reference model: raster position within a frame plus a running flag.
  bit          m_run;
  int          m_pos;
  bit          p_req, p_fs, p_hs, p_vs;
  int          p_h, p_v;
  bit          q_act, q_hs, q_vs;
  logic [23:0] q_pix;
  int          cyc = 0, fs_cnt = 0, last_fs = -1, prev_fs = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0;
    p_req = 0; p_fs = 0; p_hs = 0; p_vs = 0; p_h = 0; p_v = 0;
    q_act = 0; q_hs = 0; q_vs = 0; q_pix = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_Hpos"}, Hpos, 0);
    check({tag, "_Vpos"}, Vpos, 0);
    check({tag, "_pix_req"}, pix_req, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_Active_pix"}, Active_pix, 0);
    check({tag, "_pixel_out"}, pixel_out, 0);
    check({tag, "_Hsync"}, Hsync, 0);
    check({tag, "_Vsync"}, Vsync, 0);
  endtask

  task automatic cycle();
    int h, v;
    @(posedge vid_clk);
    cyc++;
    q_act = p_req;
    q_pix = p_req ? mem[p_v][p_h] : 24'h0;
    q_hs  = p_hs;
    q_vs  = p_vs;
    h = m_pos % HT;
    v = m_pos / HT;
    p_req = m_run && (h < HR) && (v < VR);
    p_h   = p_req ? h : 0;
    p_v   = p_req ? v : 0;
    p_fs  = m_run && (m_pos == 0);
    p_hs  = m_run && (h >= HR + HF) && (h < HR + HF + HS);
    p_vs  = m_run && (v >= VR + VF) && (v < VR + VF + VS);
    // A run ends only on the last pixel of a frame with enable low.
    if (m_run) begin
      if (m_pos == FT - 1 && !en) begin
        m_run = 0;
        m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FT;
      end
    end else if (en) begin
      m_run = 1;
    end
    #1;
    check("pix_req", pix_req, p_req);
    check("Hpos", Hpos, p_h);
    check("Vpos", Vpos, p_v);
    check("frame_start", frame_start, p_fs);
    check("Active_pix", Active_pix, q_act);
    check("pixel_out", pixel_out, q_pix);
    check("Hsync", Hsync, q_hs);
    check("Vsync", Vsync, q_vs);
    if (frame_start) begin
      fs_cnt++;
      prev_fs = last_fs;
      last_fs = cyc;
    end
  endtask

  task automatic run_until(input string tag, input int pos);
    int n;
    n = 0;
    while (!(m_run && m_pos == pos) && n < 4 * FT) begin
      cycle();
      n++;
    end
    check(tag, 32'(m_run && m_pos == pos), 1);
  endtask

  initial begin
    int fs_mark;
    for (int v = 0; v < VR; v++)
      for (int h = 0; h < HR; h++)
        mem[v][h] = 24'($urandom);
    model_reset();

    reset_n = 0;
    en      = 0;
    repeat (3) @(posedge vid_clk);
    #1;
    check_reset_values("por");
    reset_n = 1;

    repeat (50) cycle();

    en = 1;
    repeat (2 * FT + 20) cycle();
    check("fs_period", 32'(last_fs - prev_fs), FT);

    run_until("reach_v2h5", 2 * HT + 5);
    en = 0;
    fs_mark = fs_cnt;
    repeat (FT + 10) cycle();
    check("no_fs_after_stop", 32'(fs_cnt), 32'(fs_mark));

    en = 1;
    run_until("reach_stop2", 40);
    en = 0;
    repeat (7) cycle();
    en = 1;
    repeat (FT) cycle();
    check("fs_period_resume", 32'(last_fs - prev_fs), FT);

    for (int i = 0; i < 12; i++) begin
      en = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 40)) cycle();
    end

    en = 1;
    run_until("reach_v1h3", HT + 3);
    #2;
    reset_n = 0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    en = 0;
    repeat (3) cycle();
    reset_n = 1;
    repeat (2) cycle();
    en = 1;
    cycle();
    cycle();
    check("fs_restart", 32'(frame_start), 1);
    repeat (FT + 5) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
